// File: rtl/jtag_ocimem_arbiter_if.sv
// CPU debug-slave and OCI RAM signal bundle shared by the arbiter and its surroundings.
interface jtag_ocimem_arbiter_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [31:0]       cpu_writedata;
  logic [31:0]       cpu_readdata;
  logic              cpu_waitrequest;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_we;
  logic [31:0]       ram_rdata;

  modport slave (
    input  cpu_address, cpu_read, cpu_write, cpu_writedata, ram_rdata,
    output cpu_readdata, cpu_waitrequest, ram_addr, ram_wdata, ram_we
  );

  modport master (
    output cpu_address, cpu_read, cpu_write, cpu_writedata, ram_rdata,
    input  cpu_readdata, cpu_waitrequest, ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/jtag_ocimem_arbiter.sv
// Shares the single-port OCI RAM between JTAG monitor ops and the CPU debug slave,
// with an auto-incrementing JTAG address and a starvation limit on CPU wins.
module jtag_ocimem_arbiter #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [37:0]           jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  input  logic                  take_no_action_ocimem_a,
  jtag_ocimem_arbiter_if.slave  bus,
  output logic [31:0]           MonDReg,
  output logic                  monitor_ready,
  output logic                  monitor_error
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, CPU_RD, JTAG_RD} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0]       dreg_q, dreg_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              pend_q, pend_d;
  logic              pend_wr_q, pend_wr_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] ram_addr_c;
  logic [31:0]       ram_wdata_c;
  logic              ram_we_c;
  logic              wait_c;
  logic [31:0]       cpu_rdata_c;
  logic              cpu_req_c;
  logic              jstb_c;
  logic              unused_jdo_c;

  assign unused_jdo_c = ^{jdo[37:36], jdo[1:0]};
  assign cpu_req_c    = bus.cpu_read | bus.cpu_write;
  assign jstb_c       = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      maddr_q   <= '0;
      dreg_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      pend_q    <= 1'b0;
      pend_wr_q <= 1'b0;
      ready_q   <= 1'b1;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      maddr_q   <= maddr_d;
      dreg_q    <= dreg_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    maddr_d     = maddr_q;
    dreg_d      = dreg_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    pend_d      = pend_q;
    pend_wr_d   = pend_wr_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    ram_addr_c  = maddr_q;
    ram_wdata_c = wdata_q;
    ram_we_c    = 1'b0;
    wait_c      = 1'b1;
    cpu_rdata_c = rdata_q;

    // Strobe acceptance; any strobe while an op is outstanding is dropped and flagged.
    if (jstb_c) begin
      if (pend_q) begin
        err_d = 1'b1;
      end else if (take_action_ocimem_b) begin
        wdata_d   = jdo[35:4];
        pend_d    = 1'b1;
        pend_wr_d = 1'b1;
      end else if (take_action_ocimem_a) begin
        maddr_d = jdo[ADDR_W+1:2];
        err_d   = 1'b0;
        if (jdo[34]) begin
          pend_d    = 1'b1;
          pend_wr_d = 1'b0;
        end
      end else begin
        pend_d    = 1'b1;
        pend_wr_d = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (pend_q && (!cpu_req_c || cnt_q >= CNT_W'(STARVE_LIMIT))) begin
          cnt_d      = '0;
          ram_addr_c = maddr_q;
          if (pend_wr_q) begin
            ram_we_c = 1'b1;
            pend_d   = 1'b0;
            maddr_d  = maddr_q + ADDR_W'(1);
          end else begin
            state_d = JTAG_RD;
          end
        end else if (cpu_req_c) begin
          ram_addr_c = bus.cpu_address;
          if (pend_q && cnt_q < CNT_W'(STARVE_LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (bus.cpu_write) begin
            ram_we_c    = 1'b1;
            ram_wdata_c = bus.cpu_writedata;
            wait_c      = 1'b0;
          end else begin
            state_d = CPU_RD;
          end
        end
      end
      CPU_RD: begin
        wait_c      = 1'b0;
        cpu_rdata_c = bus.ram_rdata;
        rdata_d     = bus.ram_rdata;
        state_d     = IDLE;
      end
      JTAG_RD: begin
        dreg_d  = bus.ram_rdata;
        pend_d  = 1'b0;
        maddr_d = maddr_q + ADDR_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = !pend_d;
  end

  assign bus.ram_addr        = ram_addr_c;
  assign bus.ram_wdata       = ram_wdata_c;
  assign bus.ram_we          = ram_we_c;
  assign bus.cpu_waitrequest = wait_c;
  assign bus.cpu_readdata    = cpu_rdata_c;
  assign MonDReg             = dreg_q;
  assign monitor_ready       = ready_q;
  assign monitor_error       = err_q;

endmodule
